// File: rtl/output_pkg.sv
// Shared types and helpers for the output serializer: FSM state encoding
// and the beat-count function used to size the beat counter.
package output_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Number of bus beats needed to carry one result word.
  function automatic int BEATS(input int data_w, input int bus_w);
    return (bus_w > 0) ? data_w / bus_w : 0;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Circular-buffer FIFO for result words. A push while full is accepted only
// when a pop happens on the same edge; level reports post-edge occupancy.
module result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic [LVL_W-1:0] lvl_q;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (lvl_q == LVL_W'(DEPTH));
  assign empty   = (lvl_q == '0);
  assign level   = lvl_q;
  assign head    = mem_q[rd_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push_ok) wr_q <= ptr_inc(wr_q);
      if (pop_ok)  rd_q <= ptr_inc(rd_q);
      case ({push_ok, pop_ok})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/output_serializer.sv
// Queues result words and serialises each one onto a shared, arbitrated
// output bus as BEATS consecutive beats, one per granted cycle.
//
// Handshake: req is high whenever the FSM is in SEND; a beat transfers at
// every rising edge where req && gnt. gnt without req is ignored.
module output_serializer
  import output_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int BUS_W     = 8,
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 1,
  localparam int BEATS_N  = BEATS(DATA_W, BUS_W),
  localparam int CNT_W    = (BEATS_N > 2) ? $clog2(BEATS_N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_reg,
  input  logic [DATA_W-1:0] sinx,
  input  logic              gnt,
  output logic              req,
  output logic [BUS_W-1:0]  bus,
  output logic              bus_valid,
  output logic [CNT_W-1:0]  cnt,
  output logic              done,
  output logic              full,
  output logic              ovf,
  output state_e            state_dbg
);

  localparam int LVL_W = $clog2(DEPTH + 1);

  if (BUS_W < 1 || (DATA_W % BUS_W) != 0 || (DATA_W / BUS_W) < 2) begin : g_bad_width
    $fatal(1, "output_serializer: DATA_W must be a multiple of BUS_W with at least 2 beats");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "output_serializer: DEPTH must be at least 1");
  end

  state_e            state_q;
  logic [BUS_W-1:0]  bus_q;
  logic              bus_valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              done_q;
  logic              ovf_q;

  logic [DATA_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [BUS_W-1:0]  beat_d;
  logic              xfer;
  logic              last_beat;
  logic              pop;
  logic              push_ok;
  logic              more_words;

  assign xfer       = (state_q == SEND) && gnt;
  assign last_beat  = (cnt_q == CNT_W'(BEATS_N - 1));
  assign pop        = xfer && last_beat;
  assign push_ok    = ld_reg && (!fifo_full || pop);
  // A word remains after the pop if another was queued or one arrives now.
  assign more_words = (fifo_level > LVL_W'(1)) || push_ok;

  result_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ld_reg),
    .pop   (pop),
    .din   (sinx),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    beat_d = '0;
    for (int b = 0; b < BEATS_N; b++) begin
      if (cnt_q == CNT_W'(b)) begin
        beat_d = (MSB_FIRST != 0) ? head[DATA_W-1-b*BUS_W -: BUS_W]
                                  : head[b*BUS_W +: BUS_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_q       <= '0;
      bus_valid_q <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      bus_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (ld_reg && fifo_full && !pop) ovf_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= SEND;
            cnt_q   <= '0;
          end
        end
        SEND: begin
          if (gnt) begin
            bus_q       <= beat_d;
            bus_valid_q <= 1'b1;
            if (last_beat) begin
              cnt_q  <= '0;
              done_q <= 1'b1;
              if (!more_words) state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req       = (state_q == SEND);
  assign bus       = bus_q;
  assign bus_valid = bus_valid_q;
  assign cnt       = cnt_q;
  assign done      = done_q;
  assign full      = fifo_full;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_output_serializer.sv
// Directed bench for output_serializer: three instances (16/8 MSB-first,
// 16/8 LSB-first, 32/8 MSB-first) with beat scoreboards fed at load time.
module tb_output_serializer;
  import output_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus / DUT wiring ----------------
  logic        ld = 1'b0;
  logic        ld2 = 1'b0;
  logic        gnt = 1'b0;
  logic [15:0] sinx = '0;
  logic [31:0] sinx2 = '0;

  logic       req0, bv0, done0, full0, ovf0;
  logic [7:0] bus0;
  logic [0:0] cnt0;
  state_e     st0;
  logic       req1, bv1, done1, full1, ovf1;
  logic [7:0] bus1;
  logic [0:0] cnt1;
  state_e     st1;
  logic       req2, bv2, done2, full2, ovf2;
  logic [7:0] bus2;
  logic [1:0] cnt2;
  state_e     st2;

  output_serializer #(.DATA_W(16), .BUS_W(8), .DEPTH(2), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst(rst), .ld_reg(ld), .sinx(sinx), .gnt(gnt), .req(req0),
    .bus(bus0), .bus_valid(bv0), .cnt(cnt0), .done(done0), .full(full0),
    .ovf(ovf0), .state_dbg(st0));

  output_serializer #(.DATA_W(16), .BUS_W(8), .DEPTH(2), .MSB_FIRST(0)) u1 (
    .clk(clk), .rst(rst), .ld_reg(ld), .sinx(sinx), .gnt(gnt), .req(req1),
    .bus(bus1), .bus_valid(bv1), .cnt(cnt1), .done(done1), .full(full1),
    .ovf(ovf1), .state_dbg(st1));

  output_serializer #(.DATA_W(32), .BUS_W(8), .DEPTH(2), .MSB_FIRST(1)) u2 (
    .clk(clk), .rst(rst), .ld_reg(ld2), .sinx(sinx2), .gnt(gnt), .req(req2),
    .bus(bus2), .bus_valid(bv2), .cnt(cnt2), .done(done2), .full(full2),
    .ovf(ovf2), .state_dbg(st2));

  // ---------------- scoreboard ----------------
  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];
  logic [7:0] exp2_q[$];
  int checks   = 0;
  int failures = 0;
  int done0_n  = 0;
  int done1_n  = 0;
  int done2_n  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (bv0 === 1'b1) begin
      check("u0_beat_expected", 32'(exp0_q.size() != 0), 32'd1);
      if (exp0_q.size() != 0) begin
        e = exp0_q.pop_front();
        check("u0_bus", 32'(bus0), 32'(e));
      end
    end
    if (bv1 === 1'b1) begin
      check("u1_beat_expected", 32'(exp1_q.size() != 0), 32'd1);
      if (exp1_q.size() != 0) begin
        e = exp1_q.pop_front();
        check("u1_bus", 32'(bus1), 32'(e));
      end
    end
    if (bv2 === 1'b1) begin
      check("u2_beat_expected", 32'(exp2_q.size() != 0), 32'd1);
      if (exp2_q.size() != 0) begin
        e = exp2_q.pop_front();
        check("u2_bus", 32'(bus2), 32'(e));
      end
    end
    if (done0 === 1'b1) done0_n++;
    if (done1 === 1'b1) done1_n++;
    if (done2 === 1'b1) done2_n++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one word into u0/u1 for one edge; accepted words add their beats.
  task automatic load16(input logic [15:0] w, input bit accept);
    logic [15:0] wv;
    wv = w;
    if (accept) begin
      exp0_q.push_back(wv[15:8]);
      exp0_q.push_back(wv[7:0]);
      exp1_q.push_back(wv[7:0]);
      exp1_q.push_back(wv[15:8]);
    end
    ld   = 1'b1;
    sinx = w;
    tick();
    ld   = 1'b0;
  endtask

  task automatic load32(input logic [31:0] w);
    logic [31:0] wv;
    wv = w;
    exp2_q.push_back(wv[31:24]);
    exp2_q.push_back(wv[23:16]);
    exp2_q.push_back(wv[15:8]);
    exp2_q.push_back(wv[7:0]);
    ld2   = 1'b1;
    sinx2 = w;
    tick();
    ld2   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},  32'(req0), 32'd0);
    check({tag, "_bus"},  32'(bus0), 32'd0);
    check({tag, "_bv"},   32'(bv0),  32'd0);
    check({tag, "_cnt"},  32'(cnt0), 32'd0);
    check({tag, "_done"}, 32'(done0), 32'd0);
    check({tag, "_full"}, 32'(full0), 32'd0);
    check({tag, "_ovf"},  32'(ovf0), 32'd0);
    check({tag, "_st"},   32'(st0),  32'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    int d2;

    // Reset state before any clock edge.
    #2;
    check_reset_outputs("rst0");
    check("rst0_req2", 32'(req2), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 0xABCD with gnt held high: MSB-first on u0, LSB-first on u1.
    gnt = 1'b1;
    d0  = done0_n;
    load16(16'hABCD, 1'b1);
    check("lat_req_n", 32'(req0), 32'd0);
    tick();
    check("lat_req_n1", 32'(req0), 32'd1);
    check("lat_bv_n1", 32'(bv0), 32'd0);
    tick();
    check("b0_bv", 32'(bv0), 32'd1);
    check("b0_bus", 32'(bus0), 32'hAB);
    check("b0_cnt", 32'(cnt0), 32'd1);
    check("b0_done", 32'(done0), 32'd0);
    check("b0_bus_lsb", 32'(bus1), 32'hCD);
    tick();
    check("b1_bus", 32'(bus0), 32'hCD);
    check("b1_cnt", 32'(cnt0), 32'd0);
    check("b1_done", 32'(done0), 32'd1);
    check("b1_req", 32'(req0), 32'd0);
    tick();
    check("post_done", 32'(done0), 32'd0);
    check("post_bv", 32'(bv0), 32'd0);
    check("abcd_done_cnt", 32'(done0_n), 32'(d0 + 1));

    // 32/8: four beats, single done.
    d2 = done2_n;
    load32(32'h12345678);
    ticks(6);
    check("w32_done_cnt", 32'(done2_n), 32'(d2 + 1));
    check("w32_req", 32'(req2), 32'd0);
    check("w32_q_empty", 32'(exp2_q.size()), 32'd0);

    // Grant pattern 1,0,0,1.
    gnt = 1'b0;
    load16(16'hABCD, 1'b1);
    tick();
    check("gap_req", 32'(req0), 32'd1);
    gnt = 1'b1;
    tick();
    check("gap_b0_bus", 32'(bus0), 32'hAB);
    check("gap_b0_cnt", 32'(cnt0), 32'd1);
    gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("gap_hold_bv", 32'(bv0), 32'd0);
      check("gap_hold_bus", 32'(bus0), 32'hAB);
      check("gap_hold_cnt", 32'(cnt0), 32'd1);
      check("gap_hold_req", 32'(req0), 32'd1);
    end
    gnt = 1'b1;
    tick();
    check("gap_b1_bus", 32'(bus0), 32'hCD);
    check("gap_b1_done", 32'(done0), 32'd1);
    tick();

    // Overflow: third word dropped while full.
    gnt = 1'b0;
    d0  = done0_n;
    load16(16'h1111, 1'b1);
    load16(16'h2222, 1'b1);
    check("ovf_pre", 32'(ovf0), 32'd0);
    load16(16'h3333, 1'b0);
    check("ovf_full", 32'(full0), 32'd1);
    check("ovf_flag", 32'(ovf0), 32'd1);
    gnt = 1'b1;
    ticks(6);
    check("ovf_done_cnt", 32'(done0_n), 32'(d0 + 2));
    check("ovf_sticky", 32'(ovf0), 32'd1);
    check("ovf_drained", 32'(full0), 32'd0);
    check("ovf_q_empty", 32'(exp0_q.size()), 32'd0);

    // Reset clears ovf; then push while full on the pop edge.
    rst = 1'b1;
    #1;
    check("ovf_rst", 32'(ovf0), 32'd0);
    tick();
    rst = 1'b0;
    gnt = 1'b0;
    d0  = done0_n;
    load16(16'h1111, 1'b1);
    load16(16'h2222, 1'b1);
    check("pp_full", 32'(full0), 32'd1);
    gnt = 1'b1;
    tick();
    check("pp_b0_cnt", 32'(cnt0), 32'd1);
    load16(16'h4444, 1'b1);
    check("pp_ovf", 32'(ovf0), 32'd0);
    check("pp_full_after", 32'(full0), 32'd1);
    check("pp_done", 32'(done0), 32'd1);
    ticks(6);
    check("pp_done_cnt", 32'(done0_n), 32'(d0 + 3));
    check("pp_q_empty", 32'(exp0_q.size()), 32'd0);
    check("pp_ovf_end", 32'(ovf0), 32'd0);

    // Reset after the first beat discards the partial word.
    gnt = 1'b1;
    load16(16'hABCD, 1'b1);
    ticks(2);
    check("mid_b0_bus", 32'(bus0), 32'hAB);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    exp0_q.delete();
    exp1_q.delete();
    d0 = done0_n;
    ticks(2);
    rst = 1'b0;
    ticks(4);
    check("mid_no_done", 32'(done0_n), 32'(d0));
    check("mid_req", 32'(req0), 32'd0);
    check("mid_bv", 32'(bv0), 32'd0);

    // Every queued beat was produced.
    check("end_q0", 32'(exp0_q.size()), 32'd0);
    check("end_q1", 32'(exp1_q.size()), 32'd0);
    check("end_q2", 32'(exp2_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
